// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared I2C definitions for target and master sides
package iic_pkg;

  // Target FSM states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DADDR,
    ST_DACK,
    ST_RADDR,
    ST_RACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_MACK,
    ST_WAIT
  } iic_state_t;

  // Acknowledge bit levels on SDA
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Default 7-bit address of the WM8978 codec
  localparam logic [6:0] WM8978_ADDR = 7'h1A;

endpackage

// File: rtl/iic_line_cond.sv
// rtl/iic_line_cond.sv - SCL/SDA synchronizer, glitch filter and bus event pulses
module iic_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic [FILT_LEN-1:0]    scl_hist;
  logic [FILT_LEN-1:0]    sda_hist;
  logic                   scl_lvl;
  logic                   scl_prev;
  logic                   sda_prev;

  // Synchronize, then accept a new level only after FILT_LEN equal samples;
  // everything resets high so an idle bus produces no events after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_lvl  <= 1'b1;
      sda_lvl  <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[SYNC_STAGES-1]};
      if (&scl_hist)       scl_lvl <= 1'b1;
      else if (~|scl_hist) scl_lvl <= 1'b0;
      if (&sda_hist)       sda_lvl <= 1'b1;
      else if (~|sda_hist) sda_lvl <= 1'b0;
      scl_prev <= scl_lvl;
      sda_prev <= sda_lvl;
    end
  end

  // SDA edges only count as START/STOP while SCL has been stably high
  assign scl_rise = scl_lvl & ~scl_prev;
  assign scl_fall = ~scl_lvl & scl_prev;
  assign start    = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
  assign stop     = scl_lvl & scl_prev & ~sda_prev & sda_lvl;

endmodule

// File: rtl/iic_slave_regif.sv
// rtl/iic_slave_regif.sv - I2C register target with parallel write/read request port
module iic_slave_regif #(
  parameter logic [6:0] DEV_ADDR    = iic_pkg::WM8978_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  import iic_pkg::*;

  iic_state_t state;
  iic_state_t state_n;
  logic       sda_lvl;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] byte_in;
  logic [7:0] ptr;
  logic [7:0] tx_byte;
  logic [1:0] rd_cnt;
  logic       rw;
  logic       sda_oe;
  logic       last_bit;
  logic       addr_match;

  iic_line_cond #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_line_cond (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
    .sda_lvl (sda_lvl),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start_det),
    .stop    (stop_det)
  );

  // Open drain: only ever pull low, reset clears sda_oe asynchronously
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign byte_in    = {shift, sda_lvl};
  assign last_bit   = (bit_cnt == 3'd7);
  assign addr_match = (byte_in[7:1] == DEV_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state: START/STOP override everything, byte progress advances on scl_rise
  always_comb begin
    state_n = state;
    if (start_det) begin
      state_n = ST_DADDR;
    end else if (stop_det) begin
      state_n = ST_IDLE;
    end else if (scl_rise) begin
      case (state)
        ST_DADDR: if (last_bit) state_n = addr_match ? ST_DACK : ST_WAIT;
        ST_DACK:  state_n = rw ? ST_RDATA : ST_RADDR;
        ST_RADDR: if (last_bit) state_n = ST_RACK;
        ST_RACK:  state_n = ST_WDATA;
        ST_WDATA: if (last_bit) state_n = ST_WACK;
        ST_WACK:  state_n = ST_WDATA;
        ST_RDATA: if (last_bit) state_n = ST_MACK;
        ST_MACK:  state_n = (sda_lvl == ACK) ? ST_RDATA : ST_WAIT;
        default:  state_n = state;
      endcase
    end
  end

  // Datapath: bit shifting, pointer, fabric requests and SDA drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      ptr      <= 8'd0;
      tx_byte  <= 8'd0;
      rd_cnt   <= 2'd0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'd0;
      wr_data  <= 8'd0;
      rd_req   <= 1'b0;
      rd_addr  <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      // Capture read data two cycles after the rd_req pulse
      if (rd_cnt != 2'd0) rd_cnt <= rd_cnt - 2'd1;
      if (rd_cnt == 2'd1) tx_byte <= rd_data;

      if (start_det) begin
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (scl_rise) begin
          shift <= byte_in[6:0];
          case (state)
            ST_DADDR, ST_RADDR, ST_WDATA, ST_RDATA: bit_cnt <= bit_cnt + 3'd1;
            default:                                bit_cnt <= 3'd0;
          endcase
          case (state)
            ST_DADDR: begin
              if (last_bit) begin
                rw   <= byte_in[0];
                busy <= addr_match;
              end
            end
            ST_DACK: begin
              if (rw) begin
                rd_req  <= 1'b1;
                rd_addr <= ptr;
                rd_cnt  <= 2'd3;
              end
            end
            ST_RADDR: if (last_bit) ptr <= byte_in;
            ST_WDATA: begin
              if (last_bit) begin
                wr_valid <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= byte_in;
                ptr      <= ptr + 8'd1;
              end
            end
            ST_MACK: begin
              if (sda_lvl == ACK) begin
                ptr     <= ptr + 8'd1;
                rd_req  <= 1'b1;
                rd_addr <= ptr + 8'd1;
                rd_cnt  <= 2'd3;
              end
            end
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            ST_DACK, ST_RACK, ST_WACK: sda_oe <= 1'b1;
            ST_RDATA:                  sda_oe <= ~tx_byte[3'd7 - bit_cnt];
            default:                   sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_regif.sv
// tb/tb_iic_slave_regif.sv - I2C master driver and register-file model bench for iic_slave_regif
module tb_iic_slave_regif;

  localparam int         H   = 20;
  localparam logic [6:0] DEV = 7'h1A;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       scl_m = 1'b1;
  logic       m_low = 1'b0;
  logic       rd_arm = 1'b0;
  logic [7:0] rd_data_q = 8'd0;
  wire        sda;
  logic       wr_valid;
  logic       rd_req;
  logic       busy;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;
  int busy_cnt = 0;
  int slave_low_cnt = 0;

  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  fab_mem[256];
  logic [7:0]  model_mem[256];
  logic [7:0]  tx_buf[4];

  always #5 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  iic_slave_regif dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl_m),
    .sda     (sda),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data_q),
    .busy    (busy)
  );

  // Fabric side: garbage right after rd_req, real data from the next cycle on
  always @(posedge clk) begin
    if (rd_req) begin
      rd_data_q <= 8'($urandom);
      rd_arm    <= 1'b1;
    end else if (rd_arm) begin
      rd_data_q <= fab_mem[rd_addr];
      rd_arm    <= 1'b0;
    end
  end

  // Observe fabric-port activity and bus ownership away from the active edge
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_q.push_back({wr_addr, wr_data});
      fab_mem[wr_addr] = wr_data;
    end
    if (rd_req) rd_q.push_back(rd_addr);
    if (wr_valid && rd_req) overlap++;
    if (busy) busy_cnt++;
    if (sda == 1'b0 && !m_low) slave_low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rd_q.delete();
    busy_cnt = 0;
    slave_low_cnt = 0;
  endtask

  task automatic bit_out(input logic b);
    tick(H/2); m_low = ~b; tick(H/2); scl_m = 1'b1; tick(H); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      tick(H/2); m_low = 1'b0; tick(H/2); scl_m = 1'b1; tick(H);
    end
    m_low = 1'b1; tick(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(H/2); m_low = 1'b1; tick(H/2); scl_m = 1'b1; tick(H); m_low = 1'b0; tick(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    tick(H/2); m_low = 1'b0; tick(H/2); scl_m = 1'b1; tick(H/2);
    ack = sda;
    tick(H/2); scl_m = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      tick(H/2); m_low = 1'b0; tick(H/2); scl_m = 1'b1; tick(H/2);
      b[i] = sda;
      tick(H/2); scl_m = 1'b0;
    end
    bit_out(mack);
  endtask

  // Write burst of n bytes from tx_buf starting at register reg_a
  task automatic write_txn(input logic [7:0] reg_a, input int n);
    logic ack;
    logic [15:0] exp_w;
    clear_mon();
    i2c_start();
    send_byte({DEV, 1'b0}, ack); chk("wr_ack_dev", ack, 1'b0);
    send_byte(reg_a, ack);       chk("wr_ack_reg", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      send_byte(tx_buf[i], ack); chk("wr_ack_data", ack, 1'b0);
    end
    chk("wr_busy", busy, 1'b1);
    i2c_stop();
    chk("wr_busy_clr", busy, 1'b0);
    chk("wr_count", wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      exp_w = {8'(reg_a + i), tx_buf[i]};
      if (i < wr_q.size()) chk("wr_addr_data", wr_q[i], exp_w);
      model_mem[8'(reg_a + i)] = tx_buf[i];
    end
  endtask

  // Random/sequential read of n bytes at reg_a; master NACKs the last byte
  task automatic read_txn(input logic [7:0] reg_a, input int n);
    logic ack;
    logic [7:0] b;
    clear_mon();
    i2c_start();
    send_byte({DEV, 1'b0}, ack); chk("rd_ack_dev_w", ack, 1'b0);
    send_byte(reg_a, ack);       chk("rd_ack_reg", ack, 1'b0);
    i2c_start();
    send_byte({DEV, 1'b1}, ack); chk("rd_ack_dev_r", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, (i == n - 1));
      chk("rd_byte", b, model_mem[8'(reg_a + i)]);
    end
    tick(H/2);
    chk("rd_sda_released", sda, 1'b1);
    i2c_stop();
    chk("rd_req_count", rd_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rd_q.size()) chk("rd_addr", rd_q[i], 8'(reg_a + i));
    end
    chk("rd_no_write", wr_q.size(), 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] v;
    logic [7:0] r;
    int         n;

    for (int i = 0; i < 256; i++) begin
      fab_mem[i]   = 8'($urandom);
      model_mem[i] = fab_mem[i];
    end
    fab_mem[8'h10] = 8'h5A; model_mem[8'h10] = 8'h5A;
    fab_mem[8'h11] = 8'hC3; model_mem[8'h11] = 8'hC3;

    // Reset state
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(4);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_rd_addr", rd_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);

    // Single write
    tx_buf[0] = 8'hA7;
    write_txn(8'h05, 1);

    // Address mismatch
    clear_mon();
    i2c_start();
    send_byte(8'h36, ack); chk("mm_nack_dev", ack, 1'b1);
    send_byte(8'h05, ack); chk("mm_nack_reg", ack, 1'b1);
    send_byte(8'h11, ack); chk("mm_nack_data", ack, 1'b1);
    i2c_stop();
    chk("mm_sda_low", slave_low_cnt, 0);
    chk("mm_wr", wr_q.size(), 0);
    chk("mm_rd", rd_q.size(), 0);
    chk("mm_busy", busy_cnt, 0);

    // Sequential write with pointer wrap
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h02; tx_buf[2] = 8'h03;
    write_txn(8'hFE, 3);

    // Random read with repeated start
    read_txn(8'h10, 2);
    // Read back across the wrap
    read_txn(8'hFF, 2);

    // Abort mid-byte: partial data is discarded
    clear_mon();
    i2c_start();
    send_byte({DEV, 1'b0}, ack); chk("ab_ack_dev", ack, 1'b0);
    send_byte(8'h20, ack);       chk("ab_ack_reg", ack, 1'b0);
    v = 8'($urandom);
    for (int i = 7; i >= 4; i--) bit_out(v[i]);
    i2c_stop();
    chk("ab_no_wr", wr_q.size(), 0);
    chk("ab_busy", busy, 1'b0);
    tx_buf[0] = 8'($urandom);
    write_txn(8'h20, 1);

    // Reset while the target drives ACK low
    clear_mon();
    i2c_start();
    send_byte({DEV, 1'b0}, ack); chk("ra_ack_dev", ack, 1'b0);
    v = 8'($urandom);
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    tick(H/2); m_low = 1'b0; tick(H/2);
    chk("ra_ack_low", sda, 1'b0);
    chk("ra_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ra_sda_rel", sda, 1'b1);
    chk("ra_busy", busy, 1'b0);
    chk("ra_wr_addr", wr_addr, 8'h00);
    chk("ra_wr_data", wr_data, 8'h00);
    chk("ra_rd_addr", rd_addr, 8'h00);
    chk("ra_wr_valid", wr_valid, 1'b0);
    chk("ra_rd_req", rd_req, 1'b0);
    scl_m = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(H);
    tx_buf[0] = 8'($urandom); tx_buf[1] = 8'($urandom);
    write_txn(8'h33, 2);
    read_txn(8'h33, 2);

    // Randomized transactions against the register-file model
    for (int k = 0; k < 8; k++) begin
      r = 8'($urandom);
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < n; j++) tx_buf[j] = 8'($urandom);
        write_txn(r, n);
      end else begin
        read_txn(r, n);
      end
    end

    chk("no_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave_regif.md
Name: iic_slave_regif

Overview:
- I2C target (responder) that decodes the same single-address-byte write transactions our I2C master issues to the WM8978, plus the matching random and sequential reads.
- Presents decoded register writes and read requests to fabric through a simple parallel register port.
- Used as the codec-side bus model in system benches, and as an on-chip config target reachable from an external I2C master.
- Runs fully in the system clock domain, oversampling SCL/SDA; SCL is input-only, with no clock stretching.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address that is matched and ACKed.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2).
- FILT_LEN, 3, consecutive equal synchronized samples required before a line level is accepted (glitch filter).

Ports:
- clk  in  1  system clock (50 MHz nominal; must be ≥ 10× SCL rate)
- rst  in  1  asynchronous, active-high reset
- scl  in  1  I2C clock from master
- sda  inout  1  I2C data; open-drain: driven 1'b0 or 1'bz, never 1'b1
- wr_valid  out  1  one-cycle pulse, register write request
- wr_addr  out  8  register address for write
- wr_data  out  8  register write data
- rd_req  out  1  one-cycle pulse, read data requested at rd_addr
- rd_addr  out  8  register address for read
- rd_data  in  8  read data; must be valid 2 clk after rd_req
- busy  out  1  high from an addressed START until STOP or address mismatch

Behaviour:
- Reset values: sda released (z), wr_valid=0, rd_req=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state=IDLE, register pointer=0.
- Line conditioning: SCL/SDA pass through SYNC_STAGES flops, then the FILT_LEN filter; filtered levels are registered for edge detection.
  - scl_rise/scl_fall: 1-cycle pulses.
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
- Sampling and driving:
  - Bits are sampled on scl_rise, MSB first.
  - Target-driven SDA (ACK or read data) changes only on scl_fall, one clk after the pulse.
- FSM states: IDLE, DADDR, DACK, RADDR, RACK, WDATA, WACK, RDATA, MACK, WAIT.
- Bit counter: 3 bits; wraps 7→0 at each byte boundary.
- Transitions:
  - IDLE --START--> DADDR.
  - DADDR: after 8 bits compare [7:1] with DEV_ADDR.
    - Match, R/W=0 → DACK, then RADDR.
    - Match, R/W=1 → DACK, then RDATA.
    - Mismatch → WAIT; no ACK driven.
  - RADDR: 8 bits load pointer → RACK → WDATA.
  - WDATA: 8 bits → WACK.
    - At the WACK ACK slot: wr_valid pulses with wr_addr=pointer, wr_data=byte.
    - Pointer increments (8-bit wrap FF→00) → WDATA.
  - RDATA:
    - On entry: rd_req pulses with rd_addr=pointer.
    - rd_data is latched 2 clk later, before the first bit is driven on the next scl_fall.
    - Data bit = 0 drives low; data bit = 1 releases SDA.
    - After 8 bits → MACK, where SDA is released.
  - MACK: sampled 0 (ACK) → pointer+1, RDATA; sampled 1 (NACK) → WAIT.
  - WAIT: ignores bits and waits for START/STOP.
- ACK drive: SDA held low from the scl_fall after bit 8 until the scl_fall after the 9th clock.
- START in any state (repeated start) → DADDR with bit counter cleared. The pointer is retained, so write-reg-then-Sr-read works.
- STOP in any state → IDLE, SDA released, busy=0. A partial byte is discarded with no wr_valid.
- A STOP/START detected during a target-driven bit is still honoured: release SDA immediately.
- Async rst mid-transfer: SDA released in the same cycle, all state reset.
- wr_valid and rd_req are never high in the same cycle.

Decomposition:
- Shared package iic_pkg holds:
  - FSM state enum/localparams;
  - ACK=1'b0, NACK=1'b1;
  - default WM8978 address 7'h1A (also used by the master side).
- One natural sub-module, iic_line_cond: synchronizer, filter, and scl_rise/scl_fall/start/stop pulse generation. It is reusable by the master for arbitration and readback.

Test Plan:
- Write to matching address: START, 0x34, reg 0x05, data 0xA7, STOP
  - ACK after each byte;
  - one wr_valid with wr_addr=0x05, wr_data=0xA7;
  - busy falls after STOP.
- Address mismatch: START, 0x36, 0x05, 0x11 → SDA never driven low; no wr_valid/rd_req; busy stays 0.
- Sequential write: START, 0x34, 0xFE, 0x01, 0x02, 0x03, STOP
  - wr_valid three times, at addresses 0xFE, 0xFF, 0x00, with the matching data (pointer wraps).
- Random read: START, 0x34, 0x10, Sr, 0x35, model returns 0x5A then 0xC3; master ACKs the first byte and NACKs the second
  - bytes 0x5A and 0xC3 seen on SDA;
  - rd_addr 0x10 then 0x11;
  - SDA released after NACK.
- Abort: STOP after 4 data bits of a write → no wr_valid; the next full transaction decodes correctly.
- Assert rst while target drives an ACK low → SDA goes z asynchronously; outputs at reset values; the next START is decoded normally.
